alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one registered 32-bit ALU (Src_1/Src_2/Funct in, Result/Carry out, 1-clk latency)
//   between two requesters. Round-robin grant, valid/ready on request and response channels.
//   Sequences each op as issue -> wait -> respond; holds the ALU (Funct=6'b000000) when not issuing.
//   Sits between the two operand sources and the ALU instance; sole driver of the ALU inputs.
// PARAMETERS
//   ALU_LATENCY  1   clock edges from ALU input to valid Result/Carry (1..15)
//   CNT_W        16  width of completed-op counter op_count
// PORTS
//   clk          in   1   clock, all logic on posedge
//   rst_n        in   1   synchronous active-low reset
//   req0_valid   in   1   requester 0 has an op
//   req0_ready   out  1   requester 0 op accepted this cycle when valid&ready
//   req0_src1    in   32  requester 0 operand 1
//   req0_src2    in   32  requester 0 operand 2
//   req0_funct   in   6   requester 0 ALU function code
//   req1_valid / req1_ready / req1_src1 / req1_src2 / req1_funct: as requester 0
//   rsp0_valid   out  1   response for requester 0 valid
//   rsp0_ready   in   1   requester 0 takes response
//   rsp1_valid   out  1   response for requester 1 valid
//   rsp1_ready   in   1   requester 1 takes response
//   rsp_result   out  32  shared response data, valid with rspN_valid
//   rsp_carry    out  1   shared response carry
//   rsp_err      out  1   op had funct 6'b000000 (not issued)
//   alu_src1     out  32  to ALU Src_1
//   alu_src2     out  32  to ALU Src_2
//   alu_funct    out  6   to ALU Funct
//   alu_result   in   32  from ALU Result
//   alu_carry    in   1   from ALU Carry
//   busy         out  1   state != IDLE
//   op_count     out  CNT_W  count of completed response handshakes, wraps at 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, last_grant=1, all rsp/ready/busy=0, rsp data=0,
//     alu_src1/2=0, alu_funct=0, op_count=0. Mid-op reset discards the op; no response issued.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; ERR path IDLE -> RESP.
//   IDLE: grant = only valid requester; both valid -> requester != last_grant. reqN_ready=1
//     combinationally for granted N only, only in IDLE. On accept: latch src1/src2/funct, grant id,
//     last_grant<=N. funct!=0 -> ISSUE; funct==0 -> RESP with rsp_err=1, result=0, carry=0.
//   ISSUE (1 cycle): alu_src1/2 = latched operands, alu_funct = latched funct. Load wait cnt.
//   WAIT (ALU_LATENCY cycles): alu_funct=0 (ALU holds), operands held; on final WAIT edge latch
//     alu_result/alu_carry into rsp_result/rsp_carry, rsp_err=0.
//   RESP: rspN_valid=1 for granted N only; data stable until rspN_ready; on handshake edge
//     rspN_valid<=0, op_count<=op_count+1, -> IDLE. No new accept until back in IDLE.
//   Timing (ALU_LATENCY=1): accept edge E0; ISSUE E0..E1; WAIT E1..E2; rspN_valid high after E2.
//     Generic: rsp_valid after E0+ALU_LATENCY+1 edges; min op period ALU_LATENCY+3 cycles.
//   alu_funct is 0 in every state except ISSUE. Request lines ignored outside IDLE.
//   A requester dropping valid before ready: no accept, no state change.
// TESTING
//   1: req0 src1=32'h1,src2=32'h2,funct=6'h01 -> ready0 1 cycle; rsp0_valid 2 edges later,
//      rsp_result=32'h3, carry=0; op_count=1.
//   2: req1 32'hFFFFFFFF+32'h1 funct=6'h01 -> rsp1 result=32'h0, carry=1; alu_funct=0 in WAIT.
//   3: req0,req1 valid same cycle after reset -> req0 first, then req1; next tie -> req0 (alternates).
//   4: req0 funct=6'h00 -> no ISSUE, alu_funct stays 0; rsp0_valid next cycle, rsp_err=1, result=0.
//   5: rsp0_ready held 0 for 5 cycles -> rsp0_valid and data stable, req1 ready stays 0.
//   6: rst_n=0 during WAIT -> next cycle IDLE, rsp*_valid=0, alu_funct=0, op_count=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Each op runs issue -> wait -> respond; funct 0 bypasses the ALU and returns an error response.
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_src1,
    input  logic [31:0]      req0_src2,
    input  logic [5:0]       req0_funct,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_src1,
    input  logic [31:0]      req1_src2,
    input  logic [5:0]       req1_funct,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [5:0]       alu_funct,
    input  logic [31:0]      alu_result,
    input  logic             alu_carry,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_LATENCY - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      alu_src1_q, alu_src1_d;
    logic [31:0]      alu_src2_q, alu_src2_d;
    logic [5:0]       alu_funct_q, alu_funct_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             gnt_any;
    logic             gnt_id;
    logic [5:0]       sel_funct;
    logic             rsp_hs;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = req1_valid;
        end
        sel_funct  = gnt_id ? req1_funct : req0_funct;
        req0_ready = (state_q == IDLE) && gnt_any && !gnt_id;
        req1_ready = (state_q == IDLE) && gnt_any && gnt_id;
        rsp_hs     = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wait_cnt_d   = wait_cnt_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        alu_src1_d   = alu_src1_q;
        alu_src2_d   = alu_src2_q;
        alu_funct_d  = alu_funct_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    grant_d      = gnt_id;
                    last_grant_d = gnt_id;
                    alu_src1_d   = gnt_id ? req1_src1 : req0_src1;
                    alu_src2_d   = gnt_id ? req1_src2 : req0_src2;
                    alu_funct_d  = sel_funct;
                    if (sel_funct != 6'b000000) begin
                        state_d = ISSUE;
                    end else begin
                        state_d      = RESP;
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_carry_d  = 1'b0;
                        rsp0_valid_d = !gnt_id;
                        rsp1_valid_d = gnt_id;
                    end
                end
            end
            ISSUE: begin
                alu_funct_d = '0;
                wait_cnt_d  = WAIT_LOAD;
                state_d     = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_result_d = alu_result;
                    rsp_carry_d  = alu_carry;
                    rsp_err_d    = 1'b0;
                    rsp0_valid_d = !grant_q;
                    rsp1_valid_d = grant_q;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            wait_cnt_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            alu_src1_q   <= '0;
            alu_src2_q   <= '0;
            alu_funct_q  <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            alu_src1_q   <= alu_src1_d;
            alu_src2_q   <= alu_src2_d;
            alu_funct_q  <= alu_funct_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign alu_src1   = alu_src1_q;
    assign alu_src2   = alu_src2_q;
    assign alu_funct  = alu_funct_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 1-cycle ALU model, directed scenarios, then random traffic.
// Accepted ops are scored into a queue; a negedge monitor compares every response.
module tb_alu_arbiter;

    localparam int LAT   = 1;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]      req0_src1, req0_src2, req1_src1, req1_src2;
    logic [5:0]       req0_funct, req1_funct;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]      rsp_result;
    logic             rsp_carry, rsp_err;
    logic [31:0]      alu_src1, alu_src2;
    logic [5:0]       alu_funct;
    logic [31:0]      alu_result = '0;
    logic             alu_carry = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    alu_arbiter #(.ALU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_funct(req1_funct),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // funct 1 add, 2 sub (carry = borrow), 3 and, 4 or, 5 xor; returns {carry, result}
    function automatic logic [32:0] alu_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            6'd1:    return {1'b0, a} + {1'b0, b};
            6'd2:    return {(a < b), a - b};
            6'd3:    return {1'b0, a & b};
            6'd4:    return {1'b0, a | b};
            6'd5:    return {1'b0, a ^ b};
            default: return '0;
        endcase
    endfunction

    // The ALU instance: registered, holds its output while funct is 0
    always @(posedge clk) begin
        if (alu_funct != 6'd0) {alu_carry, alu_result} <= alu_op(alu_funct, alu_src1, alu_src2);
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    typedef struct {
        bit          id;
        logic [31:0] res;
        logic        carry;
        logic        err;
        int          due;
    } exp_t;

    exp_t sbq[$];
    bit   seen = 1'b0;
    bit   last_g = 1'b1;
    int   exp_cnt = 0;
    int   acc_cyc = -100;
    logic [5:0] acc_f = '0;
    int   rst_lows = 0;

    // Monitor and scoreboard, sampled on the inactive edge
    always @(negedge clk) begin
        exp_t        e;
        bit          bexp, g, vid, a;
        logic [5:0]  f, exp_f;
        logic [31:0] s1, s2;
        logic [32:0] r;
        if (!rst_n) begin
            rst_lows++;
            if (rst_lows >= 2) begin
                chk(!rsp0_valid && !rsp1_valid, "rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
                chk(!busy, "rst_busy", busy, 0);
                chk(alu_funct == 6'd0, "rst_alu_funct", alu_funct, 0);
                chk(alu_src1 == 32'd0 && alu_src2 == 32'd0, "rst_alu_src", alu_src1 | alu_src2, 0);
                chk(op_count == '0, "rst_op_count", op_count, 0);
                chk(rsp_result == 32'd0, "rst_rsp_result", rsp_result, 0);
            end
            sbq.delete();
            seen = 1'b0;
            last_g = 1'b1;
            exp_cnt = 0;
            acc_cyc = -100;
            acc_f = '0;
        end else begin
            rst_lows = 0;
            bexp = (sbq.size() != 0);
            chk(busy == bexp, "busy", busy, bexp);
            chk(op_count == CNT_W'(exp_cnt), "op_count", op_count, CNT_W'(exp_cnt));
            exp_f = (cyc == acc_cyc + 1) ? acc_f : 6'd0;
            chk(alu_funct == exp_f, "alu_funct", alu_funct, exp_f);

            if (rsp0_valid && rsp1_valid) chk(1'b0, "rsp_both_valid", 3, 1);
            if (rsp0_valid || rsp1_valid) begin
                chk(bexp, "rsp_unexpected", {rsp1_valid, rsp0_valid}, 0);
                if (bexp) begin
                    e = sbq[0];
                    vid = rsp1_valid;
                    if (!seen) begin
                        chk(cyc == e.due, "rsp_latency", cyc - acc_cyc, e.due - acc_cyc);
                        seen = 1'b1;
                    end
                    chk(vid == e.id, "rsp_id", vid, e.id);
                    chk(rsp_result == e.res, "rsp_result", rsp_result, e.res);
                    chk(rsp_carry == e.carry, "rsp_carry", rsp_carry, e.carry);
                    chk(rsp_err == e.err, "rsp_err", rsp_err, e.err);
                    if ((!vid && rsp0_ready) || (vid && rsp1_ready)) begin
                        void'(sbq.pop_front());
                        seen = 1'b0;
                        exp_cnt++;
                    end
                end
            end else if (bexp && !seen && cyc == sbq[0].due) begin
                chk(rsp0_valid || rsp1_valid, "rsp_missing", 0, 1);
            end

            if (bexp) begin
                chk(!req0_ready && !req1_ready, "ready_while_busy", {req1_ready, req0_ready}, 0);
            end else if (req0_valid || req1_valid) begin
                g = (req0_valid && req1_valid) ? !last_g : req1_valid;
                chk(req0_ready == !g && req1_ready == g, "grant", {req1_ready, req0_ready}, {g, !g});
                if (req0_ready != req1_ready) begin
                    a  = req1_ready;
                    s1 = a ? req1_src1 : req0_src1;
                    s2 = a ? req1_src2 : req0_src2;
                    f  = a ? req1_funct : req0_funct;
                    r  = alu_op(f, s1, s2);
                    e.id    = a;
                    e.err   = (f == 6'd0);
                    e.res   = e.err ? 32'd0 : r[31:0];
                    e.carry = e.err ? 1'b0 : r[32];
                    e.due   = e.err ? cyc + 1 : cyc + LAT + 2;
                    sbq.push_back(e);
                    last_g  = a;
                    acc_cyc = cyc;
                    acc_f   = f;
                end
            end else begin
                chk(!req0_ready && !req1_ready, "ready_no_req", {req1_ready, req0_ready}, 0);
            end
        end
    end

    task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        if (id) begin
            req1_src1 = a; req1_src2 = b; req1_funct = f; req1_valid = 1'b1;
        end else begin
            req0_src1 = a; req0_src2 = b; req0_funct = f; req0_valid = 1'b1;
        end
    endtask

    // Wait (bounded) until requester id is accepted, then drop its valid after the accept edge
    task automatic wait_acc(input bit id);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        chk(got, "accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = (sbq.size() == 0) && !busy;
        end
        chk(done, "idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        set_req(id, a, b, f);
        wait_acc(id);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_src1 = '0; req0_src2 = '0; req0_funct = '0;
        req1_src1 = '0; req1_src2 = '0; req1_funct = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous requests after reset: req0 (1+2) first, then req1 (FFFFFFFF+1)
        set_req(0, 32'h1, 32'h2, 6'h01);
        set_req(1, 32'hFFFF_FFFF, 32'h1, 6'h01);
        wait_acc(0);
        wait_acc(1);
        wait_idle();

        // Next tie goes back to req0
        set_req(0, 32'h5, 32'h3, 6'h02);
        set_req(1, 32'hF0, 32'h3C, 6'h03);
        wait_acc(0);
        wait_acc(1);
        wait_idle();

        // Error op bypasses the ALU
        send(0, 32'h7, 32'h9, 6'h00);
        wait_idle();

        // Response back-pressure with a competing request pending
        rsp0_ready = 1'b0;
        send(0, 32'hA, 32'h14, 6'h01);
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 6'h05);
        repeat (8) @(posedge clk);
        #1 rsp0_ready = 1'b1;
        wait_acc(1);
        wait_idle();

        // Reset while the op sits in WAIT
        send(1, 32'd100, 32'd200, 6'h02);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, 32'h40, 32'h2, 6'h04);
        wait_idle();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_src1 = pick_operand(); req0_src2 = pick_operand();
            req1_src1 = pick_operand(); req1_src2 = pick_operand();
            req0_funct = 6'($urandom_range(0, 5));
            req1_funct = 6'($urandom_range(0, 5));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        wait_idle();
        chk(sbq.size() == 0, "drain", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
